// File: rtl/wb_regfile_stage_if.sv
// wb_regfile_stage_if: MEM-to-WB inputs, ID register read ports and WB forwarding tap.
interface wb_regfile_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              FLUSH;
    logic [4:0]        WB_MEM;
    logic [DATA_W-1:0] MEM_ALU_RESULT;
    logic [DATA_W-1:0] MEM_RD_DATA;
    logic [REG_AW-1:0] MEM_RD;
    logic [DATA_W-1:0] MEM_PC_4;
    logic [REG_AW-1:0] ID_RS;
    logic [REG_AW-1:0] ID_RT;
    logic [DATA_W-1:0] ID_RS_DATA;
    logic [DATA_W-1:0] ID_RT_DATA;
    logic              WB_FWD_EN;
    logic [REG_AW-1:0] WB_FWD_RD;
    logic [DATA_W-1:0] WB_FWD_DATA;

    modport master (
        output FLUSH, WB_MEM, MEM_ALU_RESULT, MEM_RD_DATA, MEM_RD, MEM_PC_4, ID_RS, ID_RT,
        input  ID_RS_DATA, ID_RT_DATA, WB_FWD_EN, WB_FWD_RD, WB_FWD_DATA
    );

    modport slave (
        input  FLUSH, WB_MEM, MEM_ALU_RESULT, MEM_RD_DATA, MEM_RD, MEM_PC_4, ID_RS, ID_RT,
        output ID_RS_DATA, ID_RT_DATA, WB_FWD_EN, WB_FWD_RD, WB_FWD_DATA
    );
endinterface

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: MEM/WB register, write-back select, 32x32 register file with write-first bypass.
// Optional WB_RETIRE_CNT_EN adds RETIRE_CNT, a wrapping count of committed register writes.
module wb_regfile_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RESET,
`ifdef WB_RETIRE_CNT_EN
    output logic [DATA_W-1:0] RETIRE_CNT,
`endif
    wb_regfile_stage_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;

    logic [2:0]        wb_ctl;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_rdd;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_pc4;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic              unused_mem_ctl;

    assign unused_mem_ctl = ^bus.WB_MEM[1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wb_ctl <= '0;
            wb_alu <= '0;
            wb_rdd <= '0;
            wb_rd  <= '0;
            wb_pc4 <= '0;
        end else begin
            wb_ctl <= bus.FLUSH ? 3'b000 : bus.WB_MEM[4:2];
            wb_alu <= bus.MEM_ALU_RESULT;
            wb_rdd <= bus.MEM_RD_DATA;
            wb_rd  <= bus.MEM_RD;
            wb_pc4 <= bus.MEM_PC_4;
        end
    end

    // Link outranks MemtoReg so jal writes PC+4 whatever MemtoReg says.
    assign wdata = wb_ctl[2] ? wb_pc4 : wb_ctl[1] ? wb_rdd : wb_alu;
    assign wen   = wb_ctl[0] && (wb_rd != '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wen) begin
            regs[wb_rd] <= wdata;
        end
    end

    always_comb begin
        bus.ID_RS_DATA = (bus.ID_RS == '0) ? '0 : (wen && bus.ID_RS == wb_rd) ? wdata : regs[bus.ID_RS];
        bus.ID_RT_DATA = (bus.ID_RT == '0) ? '0 : (wen && bus.ID_RT == wb_rd) ? wdata : regs[bus.ID_RT];
    end

    assign bus.WB_FWD_EN   = wen;
    assign bus.WB_FWD_RD   = wb_rd;
    assign bus.WB_FWD_DATA = wdata;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) RETIRE_CNT <= '0;
        else if (wen) RETIRE_CNT <= RETIRE_CNT + 1'b1;
    end
`endif
endmodule

// File: tb/tb_wb_regfile_stage.sv
// tb_wb_regfile_stage: directed scenarios plus random traffic checked against a register-file model.
module tb_wb_regfile_stage;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wb_regfile_stage_if bus ();
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    wb_regfile_stage dut (
        .CLK(CLK),
        .RESET(RESET),
`ifdef WB_RETIRE_CNT_EN
        .RETIRE_CNT(retire_cnt),
`endif
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    // Reference: architectural registers plus the single instruction sitting in WB.
    logic [31:0] m_regs [32];
    logic [2:0]  m_wb;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdd, m_pc4;
    logic [31:0] m_cnt;

    function automatic logic [31:0] m_wdata();
        if (m_wb == 3'b101 || m_wb == 3'b111 || m_wb[2]) return m_pc4;
        if (m_wb[1]) return m_rdd;
        return m_alu;
    endfunction

    function automatic logic m_en();
        return m_wb[0] && m_rd != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_en() && a == m_rd) return m_wdata();
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_wb = 3'b000; m_rd = 5'd0; m_alu = 32'd0; m_rdd = 32'd0; m_pc4 = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic drive(input logic [4:0] wbm, input logic [31:0] alu, input logic [31:0] rdd,
                         input logic [4:0] rd, input logic [31:0] pc4, input logic flush);
        bus.WB_MEM = wbm; bus.MEM_ALU_RESULT = alu; bus.MEM_RD_DATA = rdd;
        bus.MEM_RD = rd; bus.MEM_PC_4 = pc4; bus.FLUSH = flush;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (m_en()) begin
            m_regs[m_rd] = m_wdata();
            m_cnt = m_cnt + 32'd1;
        end
        m_wb = bus.FLUSH ? 3'b000 : bus.WB_MEM[4:2];
        m_rd = bus.MEM_RD; m_alu = bus.MEM_ALU_RESULT; m_rdd = bus.MEM_RD_DATA; m_pc4 = bus.MEM_PC_4;
        #1;
    endtask

    task automatic read(input logic [4:0] rs, input logic [4:0] rt);
        bus.ID_RS = rs; bus.ID_RT = rt;
        #1;
    endtask

    task automatic test_reset();
        m_clear();
        drive(5'b00100, 32'd1, 32'd2, 5'd5, 32'd3, 1'b0);
        read(5'd5, 5'd31);
        checks++; if (bus.ID_RS_DATA !== 32'd0 || bus.WB_FWD_DATA !== 32'd0) begin errors++; $display("FAIL reset_during got rs=%h fwd=%h exp 0", bus.ID_RS_DATA, bus.WB_FWD_DATA); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        read(5'd5, 5'd31);
        checks++; if (bus.ID_RS_DATA !== 32'd0) begin errors++; $display("FAIL reset_rs got=%h exp=0", bus.ID_RS_DATA); end
        checks++; if (bus.ID_RT_DATA !== 32'd0) begin errors++; $display("FAIL reset_rt got=%h exp=0", bus.ID_RT_DATA); end
        checks++; if (bus.WB_FWD_EN !== 1'b0) begin errors++; $display("FAIL reset_fwd_en got=%b exp=0", bus.WB_FWD_EN); end
    endtask

    task automatic test_addi();
        drive(5'b00100, 32'd20, 32'd0, 5'd6, 32'd4, 1'b0);
        tick();
        checks++; if (bus.WB_FWD_EN !== 1'b1 || bus.WB_FWD_RD !== 5'd6 || bus.WB_FWD_DATA !== 32'd20) begin
            errors++; $display("FAIL addi_fwd got en=%b rd=%0d data=%0d exp en=1 rd=6 data=20", bus.WB_FWD_EN, bus.WB_FWD_RD, bus.WB_FWD_DATA); end
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        tick();
        read(5'd6, 5'd0);
        checks++; if (bus.ID_RS_DATA !== 32'd20) begin errors++; $display("FAIL addi_commit got=%0d exp=20", bus.ID_RS_DATA); end
    endtask

    task automatic test_lw_bypass();
        drive(5'b01110, 32'd123, 32'd40, 5'd7, 32'd8, 1'b0);
        tick();
        read(5'd0, 5'd7);
        checks++; if (bus.ID_RT_DATA !== 32'd40) begin errors++; $display("FAIL lw_bypass got=%0d exp=40", bus.ID_RT_DATA); end
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        tick();
        checks++; if (bus.ID_RT_DATA !== 32'd40 || bus.WB_FWD_EN !== 1'b0) begin errors++; $display("FAIL lw_commit got=%0d en=%b exp=40 en=0", bus.ID_RT_DATA, bus.WB_FWD_EN); end
    endtask

    task automatic test_jal_zero();
        drive(5'b10100, 32'd99, 32'd0, 5'd31, 32'd8, 1'b0);
        tick();
        checks++; if (bus.WB_FWD_DATA !== 32'd8) begin errors++; $display("FAIL jal_fwd got=%0d exp=8", bus.WB_FWD_DATA); end
        drive(5'b00100, 32'd55, 32'd0, 5'd0, 32'd0, 1'b0);
        tick();
        read(5'd31, 5'd0);
        checks++; if (bus.ID_RS_DATA !== 32'd8) begin errors++; $display("FAIL jal_link got=%0d exp=8", bus.ID_RS_DATA); end
        checks++; if (bus.WB_FWD_EN !== 1'b0 || bus.ID_RT_DATA !== 32'd0) begin errors++; $display("FAIL zero_write got en=%b r0=%0d exp en=0 r0=0", bus.WB_FWD_EN, bus.ID_RT_DATA); end
    endtask

    task automatic test_sw_flush();
        drive(5'b00001, 32'd1234, 32'd5678, 5'd6, 32'd0, 1'b0);
        tick();
        read(5'd6, 5'd9);
        checks++; if (bus.WB_FWD_EN !== 1'b0 || bus.ID_RS_DATA !== 32'd20) begin errors++; $display("FAIL sw_nowrite got en=%b r6=%0d exp en=0 r6=20", bus.WB_FWD_EN, bus.ID_RS_DATA); end
        drive(5'b00100, 32'd7, 32'd0, 5'd9, 32'd0, 1'b1);
        tick();
        checks++; if (bus.WB_FWD_EN !== 1'b0 || bus.ID_RT_DATA !== 32'd0) begin errors++; $display("FAIL flush_bubble got en=%b r9=%0d exp en=0 r9=0", bus.WB_FWD_EN, bus.ID_RT_DATA); end
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        tick();
        checks++; if (bus.ID_RT_DATA !== 32'd0) begin errors++; $display("FAIL flush_reg9 got=%0d exp=0", bus.ID_RT_DATA); end
    endtask

    task automatic test_flush_commit();
        drive(5'b00100, 32'd5, 32'd0, 5'd11, 32'd0, 1'b0);
        tick();
        drive(5'b00100, 32'd6, 32'd0, 5'd12, 32'd0, 1'b1);
        tick();
        read(5'd11, 5'd12);
        checks++; if (bus.ID_RS_DATA !== 32'd5) begin errors++; $display("FAIL flush_commit got=%0d exp=5", bus.ID_RS_DATA); end
        checks++; if (bus.ID_RT_DATA !== 32'd0 || bus.WB_FWD_EN !== 1'b0) begin errors++; $display("FAIL flush_incoming got=%0d en=%b exp=0 en=0", bus.ID_RT_DATA, bus.WB_FWD_EN); end
    endtask

    task automatic test_back_to_back();
        drive(5'b00100, 32'd1, 32'd0, 5'd13, 32'd0, 1'b0);
        tick();
        drive(5'b01100, 32'd0, 32'd2, 5'd13, 32'd0, 1'b0);
        tick();
        read(5'd13, 5'd13);
        checks++; if (bus.ID_RS_DATA !== 32'd2 || bus.ID_RT_DATA !== 32'd2) begin errors++; $display("FAIL b2b_bypass got=%0d/%0d exp=2", bus.ID_RS_DATA, bus.ID_RT_DATA); end
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        tick();
        checks++; if (bus.ID_RS_DATA !== 32'd2) begin errors++; $display("FAIL b2b_last_wins got=%0d exp=2", bus.ID_RS_DATA); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(5'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) == 0);
            tick();
            read(5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? bus.MEM_RD : 5'($urandom));
            checks++; if (bus.ID_RS_DATA !== m_read(bus.ID_RS)) begin errors++; $display("FAIL rand_rs[%0d] got=%h exp=%h", bus.ID_RS, bus.ID_RS_DATA, m_read(bus.ID_RS)); end
            checks++; if (bus.ID_RT_DATA !== m_read(bus.ID_RT)) begin errors++; $display("FAIL rand_rt[%0d] got=%h exp=%h", bus.ID_RT, bus.ID_RT_DATA, m_read(bus.ID_RT)); end
            checks++; if (bus.WB_FWD_EN !== m_en()) begin errors++; $display("FAIL rand_fwd_en got=%b exp=%b", bus.WB_FWD_EN, m_en()); end
            if (m_en()) begin
                checks++; if (bus.WB_FWD_RD !== m_rd || bus.WB_FWD_DATA !== m_wdata()) begin
                    errors++; $display("FAIL rand_fwd got rd=%0d data=%h exp rd=%0d data=%h", bus.WB_FWD_RD, bus.WB_FWD_DATA, m_rd, m_wdata()); end
            end
`ifdef WB_RETIRE_CNT_EN
            checks++; if (retire_cnt !== m_cnt) begin errors++; $display("FAIL rand_retire got=%0d exp=%0d", retire_cnt, m_cnt); end
`endif
        end
    endtask

    task automatic test_reset_midflight();
        drive(5'b00100, 32'd77, 32'd0, 5'd10, 32'd0, 1'b0);
        tick();
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #3 RESET = 1'b1;
        m_clear();
        read(5'd10, 5'd0);
        checks++; if (bus.WB_FWD_EN !== 1'b0 || bus.WB_FWD_DATA !== 32'd0 || bus.ID_RS_DATA !== 32'd0) begin
            errors++; $display("FAIL midreset_outputs got en=%b data=%h r10=%h exp 0", bus.WB_FWD_EN, bus.WB_FWD_DATA, bus.ID_RS_DATA); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        tick();
        checks++; if (bus.ID_RS_DATA !== 32'd0) begin errors++; $display("FAIL midreset_reg10 got=%0d exp=0", bus.ID_RS_DATA); end
`ifdef WB_RETIRE_CNT_EN
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL midreset_retire got=%0d exp=0", retire_cnt); end
`endif
    endtask

    initial begin
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        bus.ID_RS = 5'd0; bus.ID_RT = 5'd0;
        #1;
        test_reset();
        test_addi();
        test_lw_bypass();
        test_jal_zero();
        test_sw_flush();
        test_flush_commit();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
Write-back stage of the 5-stage MIPS pipeline. It sits directly downstream of the MEM stage (EX/MEM register plus data memory). It contains:
- the MEM/WB pipeline register;
- the write-back data select;
- the 32x32 register file, with read ports for ID and a same-cycle write bypass;
- a forwarding tap that exposes the WB-stage write to the EX forwarding unit.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register address width (2**REG_AW registers).

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous; loads a bubble (WB controls = 0) into MEM/WB.
- WB_MEM  in  5  MEM-stage control; [4:2] = WB controls, [1] = MemRead, [0] = MemWrite.
- MEM_ALU_RESULT  in  32  ALU result from MEM.
- MEM_RD_DATA  in  32  data memory read data.
- MEM_RD  in  5  destination register (upstream already selects 31 for jal).
- MEM_PC_4  in  32  PC+4 of the instruction.
- ID_RS  in  5  read address A.
- ID_RT  in  5  read address B.
- ID_RS_DATA  out  32  read data A (combinational).
- ID_RT_DATA  out  32  read data B (combinational).
- WB_FWD_EN  out  1  WB stage will write a nonzero register this cycle.
- WB_FWD_RD  out  5  WB destination register.
- WB_FWD_DATA  out  32  WB write data.

Behaviour:
- WB control encoding, 3 bits: WB[0] = RegWrite, WB[1] = MemtoReg, WB[2] = Link. Encodings: lw = 011, addi/R-type = 001, sw = 000, jal = 101.
- MEM/WB register:
  - On the rising edge it captures WB_MEM[4:2], MEM_ALU_RESULT, MEM_RD_DATA, MEM_RD and MEM_PC_4.
  - WB_MEM[1:0] are dropped.
  - FLUSH=1 at an edge loads WB=000. The data fields still capture but are don't-care.
- Write data select:
  - Link=1 selects PC_4.
  - Otherwise MemtoReg=1 selects RD_Data.
  - Otherwise ALU_RESULT is selected.
  - Link has priority over MemtoReg.
- Commit:
  - At the rising edge that ends the WB cycle, if RegWrite=1 and WB_RD != 0, then reg[WB_RD] <= write data.
  - Latency: an instruction captured at edge N commits at edge N+1; the value is readable through storage from then on.
- Register $0: always reads 0, is never written, and is never a bypass source.
- Read ports (combinational):
  - If the read address equals WB_RD, RegWrite=1 and the address != 0, return the WB write data (write-first bypass).
  - Otherwise return the stored value.
  - Address 0 always returns 0.
  - Both ports bypass independently. Both ports may read the same register.
- Forwarding tap:
  - WB_FWD_EN = RegWrite & (WB_RD != 0).
  - WB_FWD_RD = WB_RD.
  - WB_FWD_DATA = the selected write data.
  - All three are valid every cycle.
- Reset:
  - Asynchronous assertion clears the MEM/WB register (WB = 000, all data fields 0) and all 32 registers.
  - All outputs read 0 during reset; no write occurs.
  - Reset asserted mid-operation discards the in-flight WB instruction. That instruction does not commit.
  - Deassertion is sampled at the next edge.
- Simultaneous events:
  - FLUSH and a valid commit at the same edge: the instruction already in WB still commits; only the incoming instruction is bubbled.
  - Back-to-back writes to the same register: the last one wins. The bypass always reflects the instruction currently in WB.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined:
  - Adds output RETIRE_CNT, 32 bits: the count of committed register writes.
  - It increments by 1 at each commit edge (RegWrite=1, WB_RD != 0) and wraps from 0xFFFFFFFF to 0.
  - It clears on RESET.
  - Bubbles, sw, and writes to $0 do not count.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- RESET pulse, then read ID_RS=5 and ID_RT=31 → both 0, WB_FWD_EN=0.
- addi: WB_MEM=00100, ALU=20, RD=6 → one cycle later WB_FWD_EN=1, RD=6, DATA=20. After the next edge, ID_RS=6 reads 20.
- lw then read in the same cycle: WB_MEM=01110, RD_DATA=40, RD=7, with ID_RT=7 while the lw is in WB → ID_RT_DATA=40 via bypass before commit. After commit it reads 40 from storage.
- jal and $0:
  - WB_MEM=10100, PC_4=8, ALU=99, RD=31 → reg31 = 8 (Link priority).
  - A write of 55 to RD=0 → reg0 reads 0, WB_FWD_EN=0.
- sw and FLUSH:
  - WB_MEM=00001 → no register changes.
  - An addi to RD=9 with FLUSH=1 → reg9 is unchanged and WB_FWD_EN=0.
- Reset mid-flight: an addi to RD=10 value 77 is in WB when RESET is asserted asynchronously mid-cycle → reg10 = 0 after reset. With WB_RETIRE_CNT_EN defined, RETIRE_CNT = 0.
